dmem_copy_engine: RTL and testbench



---
 rtl/dmem_copy_engine_if.sv | 29 ++
 rtl/dmem_copy_engine.sv | 110 +++++++++++
 tb/tb_dmem_copy_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_copy_engine_if.sv
// Bundles the request handshake and the data-memory port of dmem_copy_engine.
// The engine uses the master side; the requester/memory side uses slave.
interface dmem_copy_engine_if #(
    parameter int LEN_W = 9
);
    logic             start;
    logic             op;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_data;
    logic             mem_write;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, op, src_addr, dst_addr, len, fill_data, read_data,
        output mem_write, address, write_data, busy, done, err
    );

    modport slave (
        output start, op, src_addr, dst_addr, len, fill_data, read_data,
        input  mem_write, address, write_data, busy, done, err
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// Block word-copy (memmove) / word-fill engine that owns the data-memory port while busy.
// Copy moves one word per READ/WRITE pair; fill issues back-to-back WRITEs.
module dmem_copy_engine #(
    parameter int MEM_WORDS = 256,
    parameter int LEN_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    dmem_copy_engine_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [30:0] LIMIT = 31'(MEM_WORDS);

    state_t           state_q;
    logic             op_q;
    logic             desc_q;
    logic             err_q;
    logic [31:0]      fill_q;
    logic [31:0]      hold_q;
    logic [29:0]      src_q;
    logic [29:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;

    logic [29:0] src_w, dst_w, len_m1;
    logic [30:0] src_end, dst_end;
    logic        reject_d, desc_d;
    logic [29:0] src_d, dst_d;

    // Request decode; only consumed on the start edge in IDLE.
    always_comb begin
        src_w    = bus.src_addr[31:2];
        dst_w    = bus.dst_addr[31:2];
        src_end  = {1'b0, src_w} + 31'(bus.len);
        dst_end  = {1'b0, dst_w} + 31'(bus.len);
        reject_d = (bus.dst_addr[1:0] != 2'b00)
                 | (!bus.op && (bus.src_addr[1:0] != 2'b00))
                 | (dst_end > LIMIT)
                 | (!bus.op && (src_end > LIMIT));
        desc_d   = !bus.op && (dst_w > src_w);
        len_m1   = 30'(bus.len) - 30'd1;
        src_d    = desc_d ? src_w + len_m1 : src_w;
        dst_d    = desc_d ? dst_w + len_m1 : dst_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            desc_q  <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= '0;
            hold_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        desc_q <= desc_d;
                        err_q  <= reject_d;
                        fill_q <= bus.fill_data;
                        cnt_q  <= bus.len;
                        src_q  <= src_d;
                        dst_q  <= dst_d;
                        if (reject_d || (bus.len == '0))
                            state_q <= S_DONE;
                        else
                            state_q <= bus.op ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    hold_q  <= bus.read_data;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q - LEN_W'(1);
                        src_q   <= desc_q ? src_q - 30'd1 : src_q + 30'd1;
                        dst_q   <= desc_q ? dst_q - 30'd1 : dst_q + 30'd1;
                        state_q <= op_q ? S_WRITE : S_READ;
                    end
                end
                S_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Port outputs are pure decodes of registered state, so they are glitch-free per cycle.
    assign bus.mem_write  = (state_q == S_WRITE);
    assign bus.address    = (state_q == S_READ)  ? {src_q, 2'b00} :
                            (state_q == S_WRITE) ? {dst_q, 2'b00} : 32'd0;
    assign bus.write_data = (state_q == S_WRITE) ? (op_q ? fill_q : hold_q) : 32'd0;
    assign bus.busy       = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: a behavioural memory plus a memmove/fill
// reference model predicting memory contents, address order, busy length and done timing.
module tb_dmem_copy_engine;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem     [0:255];
    logic [31:0] exp_mem [0:255];
    logic [31:0] addr_log[$];
    logic [31:0] exp_addr[$];

    dmem_copy_engine_if #(.LEN_W(9)) bus ();

    dmem_copy_engine #(.MEM_WORDS(256), .LEN_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.read_data = mem[bus.address[9:2]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.address[9:2]] = bus.write_data;
    end

    function automatic bit valid_req(input logic op, input logic [31:0] src, input logic [31:0] dst,
                                     input int ln);
        longint sw, dw;
        sw = longint'(src >> 2);
        dw = longint'(dst >> 2);
        if (dst[1:0] != 2'b00) return 1'b0;
        if (!op && src[1:0] != 2'b00) return 1'b0;
        if (dw + ln > 256) return 1'b0;
        if (!op && sw + ln > 256) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_done_k(input logic op, input bit ok, input int ln);
        if (!ok || ln == 0) return 1;
        return op ? ln + 1 : 2 * ln + 1;
    endfunction

    // memmove/fill applied to exp_mem using a snapshot of the source block; max_wr limits writes.
    task automatic model_apply(input logic op, input logic [31:0] src, input logic [31:0] dst,
                               input int ln, input logic [31:0] fd, input int max_wr);
        logic [31:0] snap[$];
        int sw, dw, i;
        bit desc;
        exp_addr.delete();
        if (!valid_req(op, src, dst, ln) || ln == 0) return;
        sw = int'(src >> 2);
        dw = int'(dst >> 2);
        desc = !op && (dw > sw);
        for (int j = 0; j < ln; j++) snap.push_back(op ? fd : exp_mem[sw + j]);
        for (int k = 0; k < ln; k++) begin
            i = desc ? ln - 1 - k : k;
            if (!op) exp_addr.push_back(32'((sw + i) * 4));
            exp_addr.push_back(32'((dw + i) * 4));
            if (k < max_wr) exp_mem[dw + i] = snap[i];
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic exercise(input logic op, input logic [31:0] src, input logic [31:0] dst,
                            input int ln, input logic [31:0] fd, input int inject_k, input int rst_wr,
                            output int done_cnt, output int done_k, output logic err_at_done,
                            output int busy_cnt, output int wr_cnt, output bit rst_out_bad,
                            output bit timeout);
        int tail;
        bit rst_pend, fin;
        done_cnt = 0; done_k = -1; err_at_done = 1'b0; busy_cnt = 0; wr_cnt = 0;
        rst_out_bad = 1'b0; tail = -1; rst_pend = 1'b0; fin = 1'b0;
        addr_log.delete();
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_addr = src; bus.dst_addr = dst;
        bus.len = 9'(ln); bus.fill_data = fd;
        for (int k = 1; k <= 700 && !fin; k++) begin
            @(negedge clk);
            bus.start = (k == inject_k);
            bus.op = 1'($urandom); bus.src_addr = $urandom; bus.dst_addr = $urandom;
            bus.len = 9'($urandom); bus.fill_data = $urandom;
            if (k == inject_k) begin
                bus.op = 1'b1; bus.dst_addr = 32'h300; bus.len = 9'd4; bus.fill_data = 32'hBAD0BAD0;
            end
            if (rst_pend) begin
                if (bus.busy || bus.done || bus.err || bus.mem_write ||
                    bus.address != 32'd0 || bus.write_data != 32'd0) rst_out_bad = 1'b1;
                reset = 1'b0; rst_pend = 1'b0; tail = k;
            end
            if (bus.busy) begin
                busy_cnt++;
                addr_log.push_back(bus.address);
            end
            if (bus.mem_write) wr_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin done_k = k; err_at_done = bus.err; end
            end
            if (rst_wr > 0 && bus.mem_write && wr_cnt == rst_wr && tail < 0) begin
                reset = 1'b1; rst_pend = 1'b1;
            end
            if (done_k > 0 && k >= done_k + 3) fin = 1'b1;
            if (tail > 0 && k >= tail + 4) fin = 1'b1;
        end
        timeout = !fin;
        bus.start = 1'b0;
    endtask

    // Full check of one request against the model (used by the scenario tasks below).
    task automatic run_and_check(input string tag, input logic op, input logic [31:0] src,
                                 input logic [31:0] dst, input int ln, input logic [31:0] fd,
                                 input bit check_order);
        int dc, dk, bc, wc, nd;
        logic er;
        bit rb, to, ok, same;
        ok = valid_req(op, src, dst, ln);
        model_apply(op, src, dst, ln, fd, 1 << 20);
        exercise(op, src, dst, ln, fd, 0, 0, dc, dk, er, bc, wc, rb, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL %s timeout: no done seen", tag); end
        n_checks++;
        if (dc != 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", tag, dc); end
        n_checks++;
        if (dk != exp_done_k(op, ok, ln)) begin
            n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", tag, dk, exp_done_k(op, ok, ln));
        end
        n_checks++;
        if (er !== !ok) begin n_fail++; $display("FAIL %s err: got %0b want %0b", tag, er, !ok); end
        n_checks++;
        if (bc != ((ok && ln > 0) ? (op ? ln : 2 * ln) : 0)) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d", tag, bc);
        end
        n_checks++;
        if (wc != ((ok) ? ln : 0)) begin
            n_fail++; $display("FAIL %s writes: got %0d want %0d", tag, wc, ok ? ln : 0);
        end
        nd = mem_diffs();
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL %s memory: %0d words differ from model", tag, nd); end
        if (check_order) begin
            same = (addr_log.size() == exp_addr.size());
            if (same) foreach (exp_addr[i]) if (addr_log[i] !== exp_addr[i]) same = 1'b0;
            n_checks++;
            if (!same) begin
                n_fail++;
                $display("FAIL %s address_order: got %0d entries want %0d", tag, addr_log.size(), exp_addr.size());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.src_addr = 32'd0; bus.dst_addr = 32'd0;
        bus.len = 9'd0; bus.fill_data = 32'd0;
        for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; exp_mem[i] = 32'd0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_write, bus.busy, bus.done, bus.err} !== 4'b0000 ||
            bus.address !== 32'd0 || bus.write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: mw=%0b busy=%0b done=%0b err=%0b addr=%h wd=%h want all 0",
                     bus.mem_write, bus.busy, bus.done, bus.err, bus.address, bus.write_data);
        end
    endtask

    task automatic test_copy_basic();
        for (int i = 0; i < 4; i++) begin mem[i] = 32'(17 * (i + 1)); exp_mem[i] = mem[i]; end
        run_and_check("copy_basic", 1'b0, 32'h000, 32'h040, 4, 32'd0, 1'b1);
        n_checks++;
        if (mem[19] !== 32'h44) begin n_fail++; $display("FAIL copy_basic_word19: got %h want 44", mem[19]); end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 5; i++) begin mem[i] = 32'(i + 1); exp_mem[i] = mem[i]; end
        run_and_check("overlap_fwd", 1'b0, 32'h000, 32'h004, 4, 32'd0, 1'b1);
        n_checks++;
        if (addr_log.size() < 3 || addr_log[0] !== 32'h00C || addr_log[1] !== 32'h010 ||
            addr_log[2] !== 32'h008) begin
            n_fail++; $display("FAIL overlap_first_addrs: got %0d entries, not 00C,010,008", addr_log.size());
        end
        n_checks++;
        if (mem[0] !== 32'd1 || mem[4] !== 32'd4) begin
            n_fail++; $display("FAIL overlap_words: mem0=%0d mem4=%0d want 1,4", mem[0], mem[4]);
        end
        run_and_check("overlap_bwd", 1'b0, 32'h008, 32'h004, 3, 32'd0, 1'b1);
        run_and_check("same_addr", 1'b0, 32'h010, 32'h010, 3, 32'd0, 1'b1);
    endtask

    task automatic test_fill();
        run_and_check("fill_top", 1'b1, 32'h0, 32'h3F0, 4, 32'hDEADBEEF, 1'b1);
        n_checks++;
        if (mem[255] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fill_word255: got %h", mem[255]); end
    endtask

    task automatic test_rejects();
        run_and_check("rej_range", 1'b0, 32'h000, 32'h3F4, 4, 32'd0, 1'b0);
        run_and_check("rej_src_unaligned", 1'b0, 32'h002, 32'h100, 4, 32'd0, 1'b0);
        run_and_check("rej_dst_unaligned", 1'b1, 32'h000, 32'h101, 2, 32'h5, 1'b0);
        run_and_check("rej_src_range", 1'b0, 32'h3FC, 32'h000, 2, 32'd0, 1'b0);
        run_and_check("rej_huge_dst", 1'b1, 32'h0, 32'hFFFF_FFF0, 4, 32'h7, 1'b0);
        run_and_check("len_zero", 1'b0, 32'h000, 32'h100, 0, 32'd0, 1'b0);
        run_and_check("fill_full_256", 1'b1, 32'h0, 32'h000, 256, 32'h0A5A5A5A, 1'b0);
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; exp_mem[i] = mem[i]; end
        for (int it = 0; it < 24; it++) begin
            logic op;
            int ln, sw, dw, kind;
            logic [31:0] src, dst;
            op = 1'($urandom);
            ln = $urandom_range(0, 40);
            dw = $urandom_range(0, 256 - ln);
            sw = $urandom_range(0, 256 - ln);
            if ($urandom_range(0, 1) == 1) begin
                sw = dw + $urandom_range(0, 6) - 3;
                if (sw < 0) sw = 0;
                if (sw > 256 - ln) sw = 256 - ln;
            end
            src = 32'(sw * 4);
            dst = 32'(dw * 4);
            kind = $urandom_range(0, 7);
            if (kind == 0) dst[1:0] = 2'($urandom_range(1, 3));
            if (kind == 1) dst = 32'((256 - ln + $urandom_range(1, 4)) * 4);
            if (kind == 2) src[1:0] = 2'($urandom_range(1, 3));
            run_and_check($sformatf("random%0d", it), op, src, dst, ln, $urandom, 1'b1);
        end
    endtask

    task automatic test_start_ignored();
        int dc, dk, bc, wc, nd;
        logic er;
        bit rb, to;
        model_apply(1'b0, 32'h080, 32'h0C0, 8, 32'd0, 1 << 20);
        exercise(1'b0, 32'h080, 32'h0C0, 8, 32'd0, 5, 0, dc, dk, er, bc, wc, rb, to);
        n_checks++;
        if (to || dc != 1 || dk != 17) begin
            n_fail++; $display("FAIL start_ignored_done: count=%0d cycle=%0d want 1 at 17", dc, dk);
        end
        n_checks++;
        if (bc != 16 || wc != 8) begin
            n_fail++; $display("FAIL start_ignored_busy: busy=%0d writes=%0d want 16,8", bc, wc);
        end
        nd = mem_diffs();
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL start_ignored_mem: %0d words differ", nd); end
    endtask

    task automatic test_reset_midop();
        int dc, dk, bc, wc, nd;
        logic er;
        bit rb, to;
        for (int i = 0; i < 8; i++) begin mem[i] = $urandom; exp_mem[i] = mem[i]; end
        model_apply(1'b0, 32'h000, 32'h200, 8, 32'd0, 3);
        exercise(1'b0, 32'h000, 32'h200, 8, 32'd0, 0, 3, dc, dk, er, bc, wc, rb, to);
        n_checks++;
        if (to || dc != 0) begin n_fail++; $display("FAIL reset_mid_done: got %0d done pulses want 0", dc); end
        n_checks++;
        if (rb) begin n_fail++; $display("FAIL reset_mid_outputs: got nonzero outputs want 0 after reset"); end
        n_checks++;
        if (wc != 3) begin n_fail++; $display("FAIL reset_mid_writes: got %0d want 3", wc); end
        nd = mem_diffs();
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL reset_mid_mem: %0d words differ (want 3 changed)", nd); end
        run_and_check("after_reset", 1'b0, 32'h000, 32'h200, 8, 32'd0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_copy_basic();
        test_overlap();
        test_fill();
        test_rejects();
        test_random_ops();
        test_start_ignored();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
